// File: rtl/dt_pkg.sv
// dt_pkg: shared state encoding, image geometry and address widths for the DT result packer
package dt_pkg;
  localparam int PIX_W = 8;
  localparam int WORD_W = 16;
  localparam int NUM_WORDS = 1024;
  localparam int RAM_AW = 14;
  localparam int ROM_AW = 10;
  localparam int K_W = 4;
  localparam int FG_W = 15;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_CAPT, ST_WRITE, ST_DONE} state_t;
endpackage

// File: rtl/dt_result_packer_if.sv
// dt_result_packer_if: control, result RAM read port and packed-word write port of the packer
// master = packer side: drives res_rd/res_addr, pk_wr/pk_addr/pk_do, busy, done, fg_count
// slave  = environment side: drives start, threshold, res_di
interface dt_result_packer_if;
  import dt_pkg::*;
  logic start;
  logic [PIX_W-1:0] threshold;
  logic res_rd;
  logic [RAM_AW-1:0] res_addr;
  logic [PIX_W-1:0] res_di;
  logic pk_wr;
  logic [ROM_AW-1:0] pk_addr;
  logic [WORD_W-1:0] pk_do;
  logic busy;
  logic done;
  logic [FG_W-1:0] fg_count;
  modport master (
    input start, threshold, res_di,
    output res_rd, res_addr, pk_wr, pk_addr, pk_do, busy, done, fg_count
  );
  modport slave (
    output start, threshold, res_di,
    input res_rd, res_addr, pk_wr, pk_addr, pk_do, busy, done, fg_count
  );
endinterface

// File: rtl/dt_result_packer_bit_packer.sv
// bit_packer: 16-bit MSB-first shift register fed by a pixel >= threshold compare
// ports: clk, reset (async high), clear, shift_en, pix, threshold -> q (current), q_nx (q after next shift)
module bit_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [PIX_W-1:0]  pix,
  input  logic [PIX_W-1:0]  threshold,
  output logic [WORD_W-1:0] q,
  output logic [WORD_W-1:0] q_nx
);
  assign q_nx = {q[WORD_W-2:0], pix >= threshold};
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (shift_en) q <= q_nx;
endmodule

// File: rtl/dt_result_packer.sv
// dt_result_packer: thresholds the 128x128 result map into 1024 packed 16-bit words in raster order
// ports: clk, reset (async high), bus (dt_result_packer_if.master: start/threshold in,
//        res_* RAM read port, pk_* word write port, busy, done, fg_count)
// PACK_STATS_EN: when defined, fg_count counts 1-pixels of the last pass; otherwise tied to 0
module dt_result_packer
  import dt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  dt_result_packer_if.master bus
);
  state_t state, state_nx;
  logic [ROM_AW-1:0] w;
  logic [K_W-1:0] k;
  logic rd_q;
  logic go;
  logic [WORD_W-1:0] word_nx;
  logic [WORD_W-1:0] word_q;
  assign go = state == ST_IDLE && bus.start;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = bus.start ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_nx = &k ? ST_CAPT : ST_FETCH;
      ST_CAPT:  state_nx = ST_WRITE;
      ST_WRITE: state_nx = w == ROM_AW'(NUM_WORDS - 1) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  assign bus.res_rd = state == ST_FETCH;
  assign bus.res_addr = {w, k};
  assign bus.pk_wr = state == ST_WRITE;
  assign bus.busy = state != ST_IDLE;
  assign bus.done = state == ST_DONE;
  // rd_q marks that res_di carries the pixel read last cycle; the 16th pixel lands during CAPT
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      w <= '0;
      k <= '0;
      rd_q <= 1'b0;
      bus.pk_addr <= '0;
      bus.pk_do <= '0;
    end else begin
      rd_q <= bus.res_rd;
      if (go) begin
        w <= '0;
        k <= '0;
      end
      if (state == ST_FETCH) k <= k + K_W'(1);
      if (state == ST_WRITE && w != ROM_AW'(NUM_WORDS - 1)) w <= w + ROM_AW'(1);
      // word and address are latched entering WRITE so they hold until the next word
      if (state == ST_CAPT) begin
        bus.pk_addr <= w;
        bus.pk_do <= word_nx;
      end
    end
  bit_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clear(go),
    .shift_en(rd_q),
    .pix(bus.res_di),
    .threshold(bus.threshold),
    .q(word_q),
    .q_nx(word_nx)
  );
`ifdef PACK_STATS_EN
  logic [FG_W-1:0] fg;
  always_ff @(posedge clk or posedge reset)
    if (reset) fg <= '0;
    else if (go) fg <= '0;
    else if (rd_q && word_nx[0]) fg <= fg + FG_W'(1);
  assign bus.fg_count = fg;
`else
  assign bus.fg_count = '0;
`endif
  logic unused;
  assign unused = ^word_q;
endmodule

// File: tb/tb_dt_result_packer.sv
// tb_dt_result_packer: scoreboard bench; expected words queued at start, monitor pops on pk_wr
module tb_dt_result_packer;
  import dt_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dt_result_packer_if bus();
  dt_result_packer dut (.clk(clk), .reset(reset), .bus(bus));
  logic [7:0] mem [16384];
  typedef struct packed {logic [9:0] a; logic [15:0] d;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_wr = 0, done_cnt = 0, done_cyc = 0, first_wr_cyc = 0;
  logic rd_s = 1'b0;
  logic [13:0] addr_s = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rd_s <= bus.res_rd;
    addr_s <= bus.res_addr;
  end
  always @(posedge clk) if (rd_s) bus.res_di <= #1 mem[addr_s];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.pk_wr) begin
      n_wr++;
      if (n_wr == 1) first_wr_cyc = cyc;
      if (q.size() == 0) check("unexpected_pk_wr", 32'(bus.pk_addr), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pk_addr", 32'(bus.pk_addr), 32'(e.a));
        check("pk_do", 32'(bus.pk_do), 32'(e.d));
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic push_pass(input logic [7:0] thr, output int fg);
    fg = 0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      logic [15:0] d;
      logic [9:0] a;
      d = '0;
      a = 10'(w);
      for (int k = 0; k < 16; k++) begin
        d[15-k] = mem[w*16+k] >= thr;
        fg += int'(d[15-k]);
      end
      q.push_back({a, d});
    end
  endtask
  task automatic start_pass(input logic [7:0] thr, output int fg, output int c0);
    @(negedge clk);
    n_wr = 0;
    done_cnt = 0;
    push_pass(thr, fg);
`ifndef PACK_STATS_EN
    fg = 0;
`endif
    bus.threshold = thr;
    bus.start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
    check("first_res_rd", 32'(bus.res_rd), 1);
    check("first_res_addr", 32'(bus.res_addr), 0);
  endtask
  task automatic run_pass(input logic [7:0] thr, input bit dbl);
    int fg, c0;
    start_pass(thr, fg, c0);
    if (dbl) begin
      repeat (40) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("done_count", 32'(done_cnt), 1);
    check("done_cycle", 32'(done_cyc - c0), 18433);
    check("first_wr_cycle", 32'(first_wr_cyc - c0), 18);
    check("write_count", 32'(n_wr), 1024);
    check("queue_empty", 32'(q.size()), 0);
    check("fg_count", 32'(bus.fg_count), 32'(fg));
    check("busy_idle", 32'(bus.busy), 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_res_rd"}, 32'(bus.res_rd), 0);
    check({tag, "_res_addr"}, 32'(bus.res_addr), 0);
    check({tag, "_pk_wr"}, 32'(bus.pk_wr), 0);
    check({tag, "_pk_addr"}, 32'(bus.pk_addr), 0);
    check({tag, "_pk_do"}, 32'(bus.pk_do), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_fg_count"}, 32'(bus.fg_count), 0);
  endtask
  initial begin
    int fg, c0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    bus.start = 1'b0;
    bus.threshold = 8'd0;
    bus.res_di = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    run_pass(8'd1, 1'b1);
    run_pass(8'd0, 1'b0);
    mem[0] = 8'd5;
    mem[17] = 8'd3;
    mem[16383] = 8'd5;
    run_pass(8'd3, 1'b0);
    start_pass(8'd4, fg, c0);
    for (int i = 0; i < 8000 && n_wr < 300; i++) @(negedge clk);
    check("writes_before_reset", 32'(n_wr), 300);
    repeat (5) @(negedge clk);
    q.delete();
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("no_wr_after_reset", 32'(n_wr), 300);
    run_pass(8'd5, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dt_result_packer.md
# dt_result_packer

Reads the 128x128 8-bit distance map from the result RAM (the res_* port written by DT) and thresholds each pixel into one bit. It packs 16 pixels per word and writes 1024 16-bit words in the sti ROM image format: bit 15 is the leftmost pixel and words are in raster order. It sits after DT in the distance-transform pipeline and lets the bench and downstream logic compare a binarised result against a golden sti image.

## Interface
- PIX_W, 8, result pixel width
- WORD_W, 16, packed word width (pixels per word)
- NUM_WORDS, 1024, words per image; pixel count = NUM_WORDS*WORD_W = 16384

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a pack pass (sampled in IDLE only)
- threshold  in  8  pixel counts as 1 when res_di >= threshold; held stable during a pass
- res_rd  out  1  result RAM read strobe
- res_addr  out  14  result RAM pixel address
- res_di  in  8  result RAM read data, valid the cycle after res_rd
- pk_wr  out  1  packed-word write strobe, one cycle per word
- pk_addr  out  10  packed word address
- pk_do  out  16  packed word data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of pass
- fg_count  out  15  count of 1-pixels in the last pass (see Configuration)

## Operation
- States: IDLE, FETCH, CAPT, WRITE, DONE.
- IDLE: all strobes low. If start=1, go to FETCH with word index w=0 and pixel index k=0.
- FETCH: res_rd=1 and res_addr={w[9:0],k[3:0]}; k increments each cycle. The result for pixel k-1 is shifted into the packing register, MSB first, when a read was issued the previous cycle. When k=15 has been issued, go to CAPT.
- CAPT: res_rd=0; capture the 16th bit; go to WRITE.
- WRITE: pk_wr=1, pk_addr=w, pk_do=packed word. If w=1023, go to DONE. Otherwise w++, k=0, return to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- Bit rule: bit(15-k) = (res_di >= threshold). threshold=0 gives all ones. threshold=255 sets only pixels equal to 255.
- start in any state other than IDLE is ignored.
- Reset mid-pass: outputs go to their reset values immediately, state returns to IDLE, and no partial word is written.

## Timing
- Reset values: res_rd=0, res_addr=0, pk_wr=0, pk_addr=0, pk_do=0, busy=0, done=0, fg_count=0.
- RAM read latency is fixed at 1 cycle; the block does not support back-pressure.
- Each word takes 18 cycles: 16 FETCH + 1 CAPT + 1 WRITE.
- The first res_rd is asserted the cycle after start.
- The first pk_wr comes 18 cycles after start.
- done rises 1024*18+1 = 18433 cycles after the start cycle.
- pk_addr and pk_do are valid only while pk_wr=1; they hold their value otherwise.
- res_addr wraps from 16383 to 0 only via a new pass.

## Configuration
- PACK_STATS_EN defined:
  - fg_count clears at start and increments for each 1-bit.
  - It is stable from done until the next start.
  - The maximum value is 16384, which needs 15 bits.
- PACK_STATS_EN undefined: the counter logic is removed and fg_count is tied to 0.

## Structure
- Shared package dt_pkg holds:
  - the state encoding (IDLE..DONE)
  - PIX_W, WORD_W, NUM_WORDS
  - the RAM and ROM address widths (14 and 10).
- One sub-module, bit_packer: a 16-bit MSB-first shift register with threshold compare, shift enable and clear.
- The FSM, the w/k counters and the stats counter stay in the top level.

## Test plan
- RAM all 0, threshold=1 -> 1024 pk_wr pulses, pk_addr 0..1023 in order, all pk_do=0x0000, done at cycle 18433, fg_count=0.
- RAM all 0, threshold=0 -> all pk_do=0xFFFF, fg_count=16384.
- Only pixel 0 = 5 and pixel 16383 = 5, threshold=5 -> word0=0x8000, word1023=0x0001, all others 0x0000, fg_count=2.
- Pixel 17 = 3, threshold=4 -> word1=0x0000; same data with threshold=3 -> word1=0x4000.
- Second start pulse during busy -> ignored: exactly 1024 writes and a single done.
- Assert reset while w=300 -> outputs 0 immediately, no further pk_wr; a new start re-runs from pk_addr=0 with correct data.
